// File: rtl/disp_pkg.sv
//==============================================================================
// Module      : disp_pkg
// Description : Shared constants for the 7-segment display blocks: blank and
//               off codes, default scan/blink timer widths and the hex-to-
//               segment lookup table (active-low gfedcba).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam int SCAN_BITS_DEF  = 17;
    localparam int BLINK_BITS_DEF = 25;

    typedef logic [2:0] digit_idx_t;

    // Entry k is the active-low gfedcba pattern for hex digit k (0..F).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

`default_nettype wire

// File: rtl/hex_to_seg.sv
//==============================================================================
// Module      : hex_to_seg
// Description : Combinational hex nibble to active-low 7-segment decoder
//               (gfedcba), full 0-F alphabet.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Straight table lookup; shared by every display block.
    assign o_seg = HEX_SEG[i_nibble];

endmodule

`default_nettype wire

// File: rtl/hex_scan8_display.sv
//==============================================================================
// Module      : hex_scan8_display
// Description : Time-multiplexes a 32-bit value onto an 8-digit common-anode
//               7-segment display with per-digit blink, decimal point and
//               enable. All per-digit inputs are snapshotted once per frame
//               so a frame never mixes old and new data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hex_scan8_display
    import disp_pkg::*;
#(
    parameter int SCAN_BITS  = SCAN_BITS_DEF,
    parameter int BLINK_BITS = BLINK_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp_data,
    input  logic [7:0]  blink,
    input  logic [7:0]  point,
    input  logic [7:0]  digit_en,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_start
);

    logic [SCAN_BITS-1:0]  r_scan_cnt;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    digit_idx_t            r_idx;
    logic [31:0]           r_sh_data;
    logic [7:0]            r_sh_blink;
    logic [7:0]            r_sh_point;
    logic [7:0]            r_sh_en;
    logic                  r_armed;
    logic [7:0]            r_an;
    logic [7:0]            r_seg;
    logic                  r_frame_start;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_blink_off;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg7;
    logic                  w_blank;

    assign w_tick      = &r_scan_cnt;
    assign w_wrap      = w_tick && (r_idx == 3'd7);
    assign w_blink_off = r_blink_cnt[BLINK_BITS-1];
    assign w_nibble    = r_sh_data[{r_idx, 2'b00} +: 4];
    assign w_blank     = !r_sh_en[r_idx] || (r_sh_blink[r_idx] && w_blink_off);

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    // Free-running dwell and blink timers; independent of each other.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Digit index advance, frame snapshot on the 7->0 wrap, frame_start pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_sh_data     <= '0;
            r_sh_blink    <= '0;
            r_sh_point    <= '0;
            r_sh_en       <= '0;
            r_armed       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_wrap) begin
                r_sh_data  <= disp_data;
                r_sh_blink <= blink;
                r_sh_point <= point;
                r_sh_en    <= digit_en;
                // Anodes stay dark until the first snapshot exists.
                r_armed    <= 1'b1;
            end
        end
    end

    // Registered anode/segment drive so both pins switch on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (r_armed) begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= w_blank ? SEG_BLANK : {~r_sh_point[r_idx], w_seg7};
        end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end
    end

    assign AN          = r_an;
    assign SEGMENT     = r_seg;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_hex_scan8_display.sv
//==============================================================================
// Module      : tb_hex_scan8_display
// Description : Self-checking bench for hex_scan8_display. Instance A uses
//               SCAN_BITS=2/BLINK_BITS=5; instance B uses BLINK_BITS=6 so its
//               blink period spans two frames and every digit (including
//               digit 2) is seen in both blink phases.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hex_scan8_display;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  blink;
        logic [7:0]  point;
        logic [7:0]  en;
        logic [63:0] seg_on;    // expected SEGMENT per digit, digit d at [8d+:8]
        logic [63:0] seg_off;   // same, during blink-off phase
        int          frames;
        int          tear_at;   // digit after which disp_data changes, -1 none
        logic [31:0] tear_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] disp_data;
    logic [7:0]  blink;
    logic [7:0]  point;
    logic [7:0]  digit_en;
    logic [7:0]  an_a, seg_a, an_b, seg_b;
    logic        fs_a, fs_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    vec_t vecs [7];

    hex_scan8_display #(.SCAN_BITS(2), .BLINK_BITS(5)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_data   (disp_data),
        .blink       (blink),
        .point       (point),
        .digit_en    (digit_en),
        .AN          (an_a),
        .SEGMENT     (seg_a),
        .frame_start (fs_a)
    );

    hex_scan8_display #(.SCAN_BITS(2), .BLINK_BITS(6)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_data   (disp_data),
        .blink       (blink),
        .point       (point),
        .digit_en    (digit_en),
        .AN          (an_b),
        .SEGMENT     (seg_b),
        .frame_start (fs_b)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply(input vec_t v);
        disp_data = v.data;
        blink     = v.blink;
        point     = v.point;
        digit_en  = v.en;
    endtask

    // Wait (bounded) for frame_start of instance A.
    task automatic wait_fs();
        bit seen = 1'b0;
        tests++;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (fs_a) seen = 1'b1;
        end
        if (!seen) begin
            fails++;
            $display("FAIL frame_start timeout: got none expected pulse within 40 clocks");
        end
    endtask

    // Dark through clock 32 after release, frame_start on 32, digit 0 lit on 33.
    task automatic first_frame(input logic [7:0] seg0);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk8($sformatf("dark AN clk%0d", k), an_a, 8'hFF);
            chk8($sformatf("dark SEG clk%0d", k), seg_a, 8'hFF);
            if (k == 31) chk1("frame_start early", fs_a, 1'b0);
            if (k == 32) chk1("frame_start first", fs_a, 1'b1);
        end
        @(posedge clk); #1;
        chk1("frame_start width", fs_a, 1'b0);
        chk8("first AN", an_a, 8'hFE);
        chk8("first SEG", seg_a, seg0);
    endtask

    // Called one clock after frame_start was seen; samples each digit mid-dwell.
    task automatic check_frame(input int vi, input vec_t v);
        logic [7:0] exp_an;
        logic       off_a, off_b;
        @(posedge clk); #1;
        for (int d = 0; d < 8; d++) begin
            @(posedge clk); #1;
            exp_an = ~(8'b1 << d);
            off_a  = ((cyc - 1) & 31) >= 16;
            off_b  = ((cyc - 1) & 63) >= 32;
            chk8($sformatf("v%0d d%0d AN A", vi, d), an_a, exp_an);
            chk8($sformatf("v%0d d%0d SEG A", vi, d), seg_a,
                 off_a ? v.seg_off[8*d +: 8] : v.seg_on[8*d +: 8]);
            chk8($sformatf("v%0d d%0d AN B", vi, d), an_b, exp_an);
            chk8($sformatf("v%0d d%0d SEG B", vi, d), seg_b,
                 off_b ? v.seg_off[8*d +: 8] : v.seg_on[8*d +: 8]);
            if (d == 0) chk1($sformatf("v%0d frame_start low", vi), fs_a, 1'b0);
            if (d == v.tear_at) disp_data = v.tear_data;
            if (d < 7) repeat (3) @(posedge clk);
        end
    endtask

    initial begin
        //            data          blink  point  en     seg_on (d7..d0)         seg_off (d7..d0)        fr tear tear_data
        vecs[0] = '{32'h87654321, 8'h00, 8'h00, 8'hFF, 64'h80F88292_99B0A4F9, 64'h80F88292_99B0A4F9, 1, -1, 32'h0};
        vecs[1] = '{32'h0000000F, 8'h04, 8'h00, 8'hFF, 64'hC0C0C0C0_C0C0C08E, 64'hC0C0C0C0_C0FFC08E, 2, -1, 32'h0};
        vecs[2] = '{32'h00000000, 8'h00, 8'h01, 8'h0F, 64'hFFFFFFFF_C0C0C040, 64'hFFFFFFFF_C0C0C040, 1, -1, 32'h0};
        vecs[3] = '{32'h00000000, 8'h00, 8'h00, 8'hFF, 64'hC0C0C0C0_C0C0C0C0, 64'hC0C0C0C0_C0C0C0C0, 1,  3, 32'hFFFFFFFF};
        vecs[4] = '{32'hFFFFFFFF, 8'h00, 8'h00, 8'hFF, 64'h8E8E8E8E_8E8E8E8E, 64'h8E8E8E8E_8E8E8E8E, 1, -1, 32'h0};
        vecs[5] = '{32'hA5C3E1B9, 8'h80, 8'hF0, 8'hFF, 64'h08124630_86F98390, 64'hFF124630_86F98390, 2, -1, 32'h0};
        vecs[6] = '{32'hFEDCBA98, 8'h00, 8'h00, 8'h7F, 64'hFF86A1C6_83889080, 64'hFF86A1C6_83889080, 1, -1, 32'h0};

        rst_n = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk8("reset AN", an_a, 8'hFF);
        chk8("reset SEG", seg_a, 8'hFF);
        chk1("reset frame_start", fs_a, 1'b0);
        rst_n = 1'b1;

        first_frame(8'hF9);

        for (int i = 0; i < 7; i++) begin
            if (i > 0) apply(vecs[i]);
            for (int f = 0; f < vecs[i].frames; f++) begin
                if (i > 0 || f > 0) wait_fs();
                check_frame(i, vecs[i]);
            end
        end

        // Reset for one clock while digit 5 is being shown.
        wait_fs();
        repeat (21) @(posedge clk);
        #1;
        chk8("pre-reset AN", an_a, 8'hDF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk8("mid reset AN", an_a, 8'hFF);
        chk8("mid reset SEG", seg_a, 8'hFF);
        chk8("mid reset AN B", an_b, 8'hFF);
        chk1("mid reset frame_start", fs_a, 1'b0);
        rst_n = 1'b1;
        first_frame(8'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
